// File: rtl/flag_pkg.sv
// flag_pkg: shared types and constants for the condition-flag controller.
//   nzcv_t       - packed {n,z,c,v}, bit order {N,Z,C,V}
//   flag_stage_t - one shadow pipeline stage: {sf, flags}
package flag_pkg;

  localparam int unsigned FLAG_W = 4;

  // Bit positions of each flag inside a raw 4-bit NZCV vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic  sf;
    nzcv_t flags;
  } flag_stage_t;

  // Unpack a raw ALU flag vector into named fields.
  function automatic nzcv_t to_nzcv(input logic [FLAG_W-1:0] raw);
    nzcv_t f;
    f.n = raw[FLAG_N];
    f.z = raw[FLAG_Z];
    f.c = raw[FLAG_C];
    f.v = raw[FLAG_V];
    return f;
  endfunction

  // Pack named flags back into a raw {N,Z,C,V} vector.
  function automatic logic [FLAG_W-1:0] from_nzcv(input nzcv_t f);
    logic [FLAG_W-1:0] raw;
    raw         = '0;
    raw[FLAG_N] = f.n;
    raw[FLAG_Z] = f.z;
    raw[FLAG_C] = f.c;
    raw[FLAG_V] = f.v;
    return raw;
  endfunction

endpackage

// File: rtl/flag_pipe_reg.sv
// flag_pipe_reg: one shadow stage register for in-flight flag updates.
// Ports:
//   clk, reset - clock, synchronous active-high reset (highest priority)
//   hold       - freeze the stage (pipeline hold)
//   clear      - load an empty stage instead of d (only when not held)
//   d          - next stage contents
//   q          - current stage contents
module flag_pipe_reg
  import flag_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        clear,
  input  flag_stage_t d,
  output flag_stage_t q
);

  // Reset wins over hold; hold wins over clear so a frozen stage keeps its entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (!hold) begin
      if (clear) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/flag_ctrl.sv
// flag_ctrl: tracks NZCV updates through MEM/WB shadow stages, holds the
// architectural flags, forwards the youngest pending flags to ID and
// flags an ID stall when the needed flags are still in EX.
// Build option: FLAG_EX_FWD_EN forwards ex_flags straight to ID and
// removes the stall.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   pipe_hold      - global freeze of all stage registers
//   ex_valid, ex_setflags, ex_flags, ex_kill - EX instruction flag update
//   id_valid, id_uses_flags - ID instruction reads NZCV
//   id_flags       - flags for the ID branch condition (combinational)
//   flag_stall     - ID must stall this cycle (combinational)
//   nzcv           - architectural flags (registered)
//   stall_cnt      - saturating count of stall cycles (registered)
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_hold,
  input  logic             ex_valid,
  input  logic             ex_setflags,
  input  logic [3:0]       ex_flags,
  input  logic             ex_kill,
  input  logic             id_valid,
  input  logic             id_uses_flags,
  output logic [3:0]       id_flags,
  output logic             flag_stall,
  output logic [3:0]       nzcv,
  output logic [CNT_W-1:0] stall_cnt
);

  flag_stage_t mem_d;
  flag_stage_t mem_q;
  flag_stage_t wb_q;
  logic        ex_live;

  // EX carries a real flag update only when it is live, setting and not squashed.
  assign ex_live = ex_valid & ex_setflags & ~ex_kill;

  always_comb begin
    mem_d       = '0;
    mem_d.sf    = ex_valid & ex_setflags;
    mem_d.flags = to_nzcv(ex_flags);
  end

  // A squashed EX instruction enters MEM as a bubble.
  flag_pipe_reg u_mem (
    .clk   (clk),
    .reset (reset),
    .hold  (pipe_hold),
    .clear (ex_kill),
    .d     (mem_d),
    .q     (mem_q)
  );

  flag_pipe_reg u_wb (
    .clk   (clk),
    .reset (reset),
    .hold  (pipe_hold),
    .clear (1'b0),
    .d     (mem_q),
    .q     (wb_q)
  );

  // Architectural commit from WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv <= 4'b0000;
    end else if (!pipe_hold && wb_q.sf) begin
      nzcv <= from_nzcv(wb_q.flags);
    end
  end

  // Youngest pending update wins; WB forwarding matches the value it commits.
  always_comb begin
    id_flags = nzcv;
`ifdef FLAG_EX_FWD_EN
    if (ex_live) begin
      id_flags = ex_flags;
    end else if (mem_q.sf) begin
      id_flags = from_nzcv(mem_q.flags);
    end else if (wb_q.sf) begin
      id_flags = from_nzcv(wb_q.flags);
    end
`else
    if (mem_q.sf) begin
      id_flags = from_nzcv(mem_q.flags);
    end else if (wb_q.sf) begin
      id_flags = from_nzcv(wb_q.flags);
    end
`endif
  end

`ifdef FLAG_EX_FWD_EN
  assign flag_stall = 1'b0;
`else
  // Flags still being computed in EX cannot reach ID this cycle.
  assign flag_stall = id_valid & id_uses_flags & ex_live;
`endif

  // Saturating stall-cycle counter; frozen cycles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (flag_stall && !pipe_hold && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/flag_ctrl.md
# flag_ctrl

Condition-flag controller for the 5-stage pipelined core. It tracks in-flight NZCV updates from flag-setting instructions (ADDS, SUBS, ANDS, CMP) through EX, MEM and WB, and holds the architectural NZCV register committed at WB. It forwards the youngest pending flags to the conditional-branch resolver in ID, and raises a stall when the flags ID needs are not yet available. It sits beside the hazard unit and replaces ad-hoc per-flag registers.

## Interface
Parameters:
- CNT_W, default 16: width of the saturating stall-event counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pipe_hold  in  1  global pipeline freeze; all internal stage registers hold
- ex_valid  in  1  EX holds a live instruction
- ex_setflags  in  1  the EX instruction writes NZCV
- ex_flags  in  4  NZCV from the ALU, bit order {N,Z,C,V}
- ex_kill  in  1  squash the EX instruction (branch flush); it enters MEM as a bubble
- id_valid  in  1  ID holds a live instruction
- id_uses_flags  in  1  the ID instruction reads NZCV (B.cond)
- id_flags  out  4  flags presented to the ID branch condition check
- flag_stall  out  1  ID must stall this cycle
- nzcv  out  4  architectural flags
- stall_cnt  out  CNT_W  number of cycles flag_stall was asserted, saturating

## Operation
- Shadow stages MEM and WB each hold {sf, flags[3:0]}.
- Each cycle without pipe_hold:
  - MEM.sf is loaded with ex_valid & ex_setflags & ~ex_kill. MEM.flags is loaded with ex_flags.
  - WB is loaded from MEM.
  - If WB.sf is set, nzcv is loaded with WB.flags.
- With pipe_hold: MEM, WB, nzcv and stall_cnt all hold. flag_stall is still computed combinationally.
- id_flags forwarding priority, youngest first: EX (only when FLAG_EX_FWD_EN), then MEM if MEM.sf, then WB if WB.sf, else nzcv.
- flag_stall = id_valid & id_uses_flags & ex_valid & ex_setflags & ~ex_kill.
  - This is forced to 0 when FLAG_EX_FWD_EN is defined.
- flag_stall does not bubble EX by itself. The hazard unit consumes it and drives ex_valid=0 on the next cycle.
- stall_cnt increments on each cycle where flag_stall=1 and pipe_hold=0. It saturates at all-ones.
- The WB-to-nzcv write and WB forwarding happen in the same cycle. ID sees identical values either way.

## Timing
- Reset values: MEM.sf=0, WB.sf=0, nzcv=4'b0000, stall_cnt=0, flag_stall=0 (because ex_valid=0 after reset is expected), id_flags=4'b0000.
- Reset takes priority over pipe_hold.
- Reset mid-operation discards all pending updates; no partial commit.
- Commit latency: a flag write in EX at cycle t is visible on nzcv at t+3.
- Forward latency:
  - Without the macro: MEM forwarding is available at t+1, so a dependent B.cond stalls exactly 1 cycle.
  - With the macro: 0 stall cycles.
- ex_kill together with ex_setflags: no update, no stall.
- Back-to-back flag setters: the youngest wins, both for forwarding and for the final nzcv value.
- id_flags and flag_stall are combinational from inputs and stage registers. All other outputs are registered.

## Configuration
- FLAG_EX_FWD_EN defined:
  - ex_flags is forwarded combinationally to id_flags at highest priority.
  - flag_stall is tied to 0.
  - This adds an ALU-to-branch timing path.
- Not defined:
  - EX is never forwarded.
  - A B.cond directly behind a flag setter gets a 1-cycle stall.

## Structure
- flag_pkg:
  - typedef nzcv_t, a packed struct {n,z,c,v}.
  - Bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flag_stage_t, a packed struct {sf, nzcv_t flags}.
- Sub-module flag_pipe_reg: one stage register with reset, hold and clear. It is instantiated for MEM and WB. The forwarding mux and counter stay in flag_ctrl.

## Test plan
- Reset, then idle 5 cycles → nzcv=0000, stall_cnt=0, id_flags=0000, flag_stall=0.
- SUBS in EX with ex_flags=0110 at cycle 1, no B.cond → nzcv=0110 at cycle 4; id_flags=0110 from cycle 2 onward.
- SUBS (1000) in EX, B.cond in ID in the same cycle, macro off → flag_stall=1 for 1 cycle, stall_cnt=1; next cycle id_flags=1000, flag_stall=0. With macro on → id_flags=1000 immediately, flag_stall=0.
- ADDS 0001 then ADDS 0100 back-to-back, B.cond 2 cycles later → id_flags=0100; final nzcv=0100.
- ex_kill with SUBS 1111 while nzcv=0010 → no stall, nzcv remains 0010 after 4 cycles.
- SUBS 0011 in EX, pipe_hold=1 for 3 cycles, then release → nzcv=0011 three cycles after release; stall_cnt is unchanged during the hold. Reset asserted mid-hold → all state 0.
